key_event_unit: RTL and testbench

KEY_EVENT_UNIT -- requirements
Module: key_event_unit

---
 rtl/key_event_pkg.sv | 32 +++
 rtl/key_debounce.sv | 54 +++++
 rtl/key_event_unit.sv | 107 ++++++++++
 tb/tb_key_event_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared constants for the pushbutton event unit: status field positions and
// parameter defaults, plus the status-word packing helper.
package key_event_pkg;

    localparam int KEU_NUM_KEYS_DEF = 3;
    localparam int KEU_DEBOUNCE_DEF = 500000;

    localparam int ST_FIELD_W     = 4;
    localparam int ST_STABLE_LSB  = 0;
    localparam int ST_PRESS_LSB   = 4;
    localparam int ST_REL_LSB     = 8;
    localparam int ST_OVF_LSB     = 12;
    localparam int ST_MASK_LSB    = 16;

    function automatic logic [31:0] pack_status(
        input logic [ST_FIELD_W-1:0] stable,
        input logic [ST_FIELD_W-1:0] press,
        input logic [ST_FIELD_W-1:0] rel,
        input logic [ST_FIELD_W-1:0] ovf,
        input logic [ST_FIELD_W-1:0] mask
    );
        logic [31:0] word;
        word = 32'd0;
        word[ST_STABLE_LSB +: ST_FIELD_W] = stable;
        word[ST_PRESS_LSB  +: ST_FIELD_W] = press;
        word[ST_REL_LSB    +: ST_FIELD_W] = rel;
        word[ST_OVF_LSB    +: ST_FIELD_W] = ovf;
        word[ST_MASK_LSB   +: ST_FIELD_W] = mask;
        return word;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and accepted-level
// register; o_rise/o_fall strobe on the edge where the stable level flips.
module key_debounce
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEU_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;

    assign w_diff = r_sync2 ^ r_stable;
    assign w_done = w_diff & (r_cnt == CNT_MAX);

    // Inversion sits ahead of the flops so a cleared synchronizer means "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_done) begin
                r_cnt    <= {CNT_W{1'b0}};
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_done &  r_sync2;
    assign o_fall   = w_done & ~r_sync2;

endmodule

// File: rtl/key_event_unit.sv
// Debounced pushbutton block with sticky press/release events, overflow flags,
// IRQ enable mask, a registered CPU status word and a level interrupt.
module key_event_unit
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS        = KEU_NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = KEU_DEBOUNCE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         wr_data,
    output logic [31:0]         status,
    output logic                irq
);

    logic [NUM_KEYS-1:0]   w_stable;
    logic [NUM_KEYS-1:0]   w_rise;
    logic [NUM_KEYS-1:0]   w_fall;
    logic [NUM_KEYS-1:0]   r_press;
    logic [NUM_KEYS-1:0]   r_rel;
    logic [NUM_KEYS-1:0]   r_ovf;
    logic [NUM_KEYS-1:0]   r_ie_mask;
    logic [NUM_KEYS-1:0]   w_press_nxt;
    logic [NUM_KEYS-1:0]   w_rel_nxt;
    logic [NUM_KEYS-1:0]   w_ovf_nxt;
    logic [ST_FIELD_W-1:0] w_f_stable;
    logic [ST_FIELD_W-1:0] w_f_press;
    logic [ST_FIELD_W-1:0] w_f_rel;
    logic [ST_FIELD_W-1:0] w_f_ovf;
    logic [ST_FIELD_W-1:0] w_f_mask;
    logic [31:0]           r_status;
    logic                  r_irq;
    logic                  w_unused_wdata;

    assign w_unused_wdata = ^wr_data[31:NUM_KEYS];

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_key_n  (key_n[g]),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    // Event capture; a read clears old events but a same-edge new event survives.
    always_comb begin
        w_press_nxt = r_press | w_rise;
        w_rel_nxt   = r_rel | w_fall;
        w_ovf_nxt   = r_ovf | (r_press & w_rise) | (r_rel & w_fall);
        if (rd_en) begin
            w_press_nxt = w_rise;
            w_rel_nxt   = w_fall;
            w_ovf_nxt   = {NUM_KEYS{1'b0}};
        end else begin
            w_press_nxt = r_press | w_rise;
        end
    end

    // Zero-extend per-key vectors into the fixed-width status fields.
    always_comb begin
        w_f_stable = {ST_FIELD_W{1'b0}};
        w_f_press  = {ST_FIELD_W{1'b0}};
        w_f_rel    = {ST_FIELD_W{1'b0}};
        w_f_ovf    = {ST_FIELD_W{1'b0}};
        w_f_mask   = {ST_FIELD_W{1'b0}};
        w_f_stable[NUM_KEYS-1:0] = w_stable;
        w_f_press[NUM_KEYS-1:0]  = r_press;
        w_f_rel[NUM_KEYS-1:0]    = r_rel;
        w_f_ovf[NUM_KEYS-1:0]    = r_ovf;
        w_f_mask[NUM_KEYS-1:0]   = r_ie_mask;
    end

    // Event, mask and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press   <= {NUM_KEYS{1'b0}};
            r_rel     <= {NUM_KEYS{1'b0}};
            r_ovf     <= {NUM_KEYS{1'b0}};
            r_ie_mask <= {NUM_KEYS{1'b0}};
            r_status  <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            r_press  <= w_press_nxt;
            r_rel    <= w_rel_nxt;
            r_ovf    <= w_ovf_nxt;
            r_status <= pack_status(w_f_stable, w_f_press, w_f_rel, w_f_ovf, w_f_mask);
            r_irq    <= |(r_press & r_ie_mask);
            if (wr_en) begin
                r_ie_mask <= wr_data[NUM_KEYS-1:0];
            end else begin
                r_ie_mask <= r_ie_mask;
            end
        end
    end

    assign status = r_status;
    assign irq    = r_irq;

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit (3 keys, 4-cycle debounce): directed scenarios with
// fixed expected words, then random key/CPU traffic against a history-based model.
module tb_key_event_unit;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam logic [7:0] DMASK = 8'((1 << DB) - 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  key_n = 3'b111;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] status;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Model: a key's accepted level flips once its synchronized sample has
    // disagreed with it for DB consecutive edges.
    logic [7:0]  m_raw [NK];
    logic [7:0]  m_dh  [NK];
    logic [2:0]  m_stable, m_press, m_rel, m_ovf, m_mask;
    logic [31:0] m_status;
    logic        m_irq;

    key_event_unit #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_n),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .status  (status),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [2:0] s, input logic [2:0] p,
                                         input logic [2:0] r, input logic [2:0] o,
                                         input logic [2:0] m);
        return {13'd0, m, 1'b0, o, 1'b0, r, 1'b0, p, 1'b0, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_raw[k] = 8'd0;
            m_dh[k]  = 8'd0;
        end
        m_stable = 3'd0; m_press = 3'd0; m_rel = 3'd0; m_ovf = 3'd0; m_mask = 3'd0;
        m_status = 32'd0;
        m_irq    = 1'b0;
    endtask

    task automatic tick();
        logic [31:0] st_n;
        logic        irq_n;
        logic [2:0]  rise;
        logic [2:0]  fall;
        rise = 3'd0;
        fall = 3'd0;
        if (rst_n) begin
            st_n  = pack(m_stable, m_press, m_rel, m_ovf, m_mask);
            irq_n = |(m_press & m_mask);
            for (int k = 0; k < NK; k++) begin
                m_dh[k]  = {m_dh[k][6:0], m_raw[k][1]};
                m_raw[k] = {m_raw[k][6:0], ~key_n[k]};
                if (!m_stable[k] && ((m_dh[k] & DMASK) == DMASK)) rise[k] = 1'b1;
                if (m_stable[k] && ((m_dh[k] & DMASK) == 8'd0)) fall[k] = 1'b1;
            end
            m_stable = m_stable ^ rise ^ fall;
            if (rd_en) begin
                m_press = rise;
                m_rel   = fall;
                m_ovf   = 3'd0;
            end else begin
                m_ovf   = m_ovf | (m_press & rise) | (m_rel & fall);
                m_press = m_press | rise;
                m_rel   = m_rel | fall;
            end
            if (wr_en) m_mask = wr_data[2:0];
            m_status = st_n;
            m_irq    = irq_n;
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
        check("model_status", status, m_status);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_clear();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        int hold [NK];
        model_reset();
        #1;
        check("reset_status", status, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(3);

        // Glitch of 3 cycles on key 1 is rejected.
        key_n = 3'b101;
        ticks(3);
        key_n = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sc1_glitch", status, 32'd0);
        end

        // Held press on key 1: visible after 2+4 edges plus the status register.
        key_n = 3'b101;
        ticks(6);
        check("sc2_before", status, 32'd0);
        tick();
        check("sc2_press", status, 32'h0000_0022);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("sc2_after_read", status, 32'h0000_0002);
        key_n = 3'b111;
        ticks(8);
        check("sc2_release", status, 32'h0000_0200);
        read_clear();
        check("sc2_idle", status, 32'd0);

        // Two presses of key 0 without a read set overflow.
        key_n = 3'b110; ticks(8);
        key_n = 3'b111; ticks(8);
        key_n = 3'b110; ticks(8);
        check("sc3_ovf", status, 32'h0000_1111);
        read_clear();
        check("sc3_cleared", status, 32'h0000_0001);
        key_n = 3'b111; ticks(8);
        read_clear();

        // IRQ mask on key 2 only.
        wr_data = 32'h0000_0004;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        check("sc4_mask", status, 32'h0004_0000);
        key_n = 3'b011;
        ticks(6);
        check("sc4_irq_early", {31'd0, irq}, 32'd0);
        tick();
        check("sc4_irq", {31'd0, irq}, 32'd1);
        check("sc4_status", status, 32'h0004_0044);
        key_n = 3'b111; ticks(8);
        read_clear();
        check("sc4_irq_cleared", {31'd0, irq}, 32'd0);
        key_n = 3'b110;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("sc4_irq_masked", {31'd0, irq}, 32'd0);
        end
        key_n = 3'b111; ticks(8);

        // Read on the very edge a new press of key 0 lands (press_evt[0] already 1).
        key_n = 3'b110;
        ticks(5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("sc5_press_kept", {31'd0, status[4]}, 32'd1);
        check("sc5_no_ovf", {31'd0, status[12]}, 32'd0);
        check("sc5_status", status, 32'h0004_0011);
        key_n = 3'b111; ticks(8);
        read_clear();

        // Reset mid-debounce with key 1 held discards the partial count.
        key_n = 3'b101;
        ticks(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("sc6_async_status", status, 32'd0);
        check("sc6_async_irq", {31'd0, irq}, 32'd0);
        ticks(2);
        check("sc6_in_reset", status, 32'd0);
        rst_n = 1'b1;
        ticks(6);
        check("sc6_before", status, 32'd0);
        tick();
        check("sc6_press", status, 32'h0000_0022);

        // Random key activity with glitches, reads and mask writes.
        for (int k = 0; k < NK; k++) hold[k] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    hold[k]  = int'($urandom_range(1, 9));
                end else begin
                    hold[k] = hold[k] - 1;
                end
            end
            rd_en   = ($urandom_range(0, 7) == 0);
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_data = $urandom;
            tick();
        end
        rd_en = 1'b0;
        wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
